mem_ctrl: RTL and testbench
===========================

# mem_ctrl

Memory-access sequencer that drives the 512 x 32 RAM from the CPU side. It owns the MAR and MDR registers and generates the RAM's `read` and `write` strobes. It accepts single-word or burst read/write requests from the datapath over a req/done handshake, auto-increments the address per beat, and returns read data with a per-word valid pulse. It sits between the control unit/datapath bus and the `ram` instance and is the only driver of the RAM's address, data and strobe inputs.

## Interface
Parameters:
- `ADDR_W`, 9: RAM address width (512 words).
- `DATA_W`, 32: word width.
- `RD_WAIT`, 1: cycles `read` is held per beat before `mem_q` is sampled; legal range 1..15.

Ports:
- `clk` in 1: system clock; all state changes on rising edge.
- `reset` in 1: asynchronous, active-high; forces IDLE and clears all registers.
- `req` in 1: transaction request; sampled only in IDLE.
- `we` in 1: 1 = write transaction, 0 = read; sampled with `req`.
- `addr` in ADDR_W: start address; sampled with `req`.
- `burst_len` in 4: beats minus one (0 = single word, 15 = 16 words); sampled with `req`.
- `wdata` in DATA_W: write word; captured when `wdata_ack` is high at a clock edge.
- `wdata_ack` out 1: combinational; high in any cycle where `wdata` is captured at the coming edge.
- `rdata` out DATA_W: registered read word.
- `rdata_valid` out 1: one-cycle pulse per read beat; `rdata` is valid in that cycle.
- `busy` out 1: high from the cycle after acceptance through DONE inclusive.
- `done` out 1: one-cycle pulse in DONE.
- `MARout` out ADDR_W: RAM address (MAR register).
- `mem_d` out DATA_W: RAM write data (MDR register).
- `mem_q` in DATA_W: RAM read data. Only meaningful while `read`=1 and `write`=0.
- `read` out 1: RAM read strobe.
- `write` out 1: RAM write strobe.

## Operation
- States: IDLE, RD, WR, DONE.
- IDLE:
  - On `req`=1 and `we`=0: MAR<=`addr`, beats<=`burst_len`, wait counter<=0, go to RD.
  - On `req`=1 and `we`=1: MAR<=`addr`, MDR<=`wdata`, beats<=`burst_len`, go to WR. `wdata_ack`=1 in this cycle.
  - `req`=0: stay in IDLE.
- RD:
  - `read`=1 throughout, `write`=0.
  - Wait counter increments each cycle.
  - On the edge ending the RD_WAIT-th cycle of a beat: `rdata`<=`mem_q`, `rdata_valid`<=1 (next cycle), counter<=0.
  - Then, if beats>0: beats-1, MAR+1, stay in RD. Otherwise go to DONE.
- WR:
  - `write`=1, `read`=0, one cycle per beat.
  - RAM commits MDR at MAR on the edge ending the cycle.
  - If beats>0: `wdata_ack`=1 this cycle, MDR<=`wdata`, MAR+1, beats-1, stay in WR. Otherwise go to DONE with `wdata_ack`=0.
- DONE: `done`=1, `read`=`write`=0, go to IDLE unconditionally.
- Address arithmetic: MAR increments modulo 2^ADDR_W; 0x1FF+1 = 0x000. No error flag.
- `req`, `we`, `addr` and `burst_len` are ignored outside IDLE. A request held high through DONE is accepted in the following IDLE cycle.
- `read` and `write` are never both high.
- `rdata` holds its last value between beats and after the transaction.

## Timing
- Reset values: state IDLE; MAR=0, MDR=0, `rdata`=0; `rdata_valid`, `done`, `busy`, `read`, `write`, `wdata_ack` all 0. Counters are 0.
- Reset mid-transaction:
  - Strobes drop asynchronously; no further RAM write occurs.
  - Words already written remain.
  - No `done` pulse is issued.
- Single read: `req` in cycle 0, `read` in cycles 1..RD_WAIT, `rdata_valid` and `done` both in cycle RD_WAIT+1. With RD_WAIT=1, `done` comes 2 cycles after `req`.
- Read burst of N beats: one word every RD_WAIT cycles with `read` held continuously. The last `rdata_valid` coincides with `done`.
- Write of N beats:
  - `write` is high in cycles 1..N; `done` is in cycle N+1.
  - `wdata_ack` is high in cycles 0..N-1, so the source presents word k+1 in the cycle after word k's ack.
- Minimum request-to-request spacing is 2 cycles after `done` for a new `req` edge; 1 cycle if `req` is held.

## Test plan
- Reset: assert `reset` asynchronously mid-cycle -> all outputs 0 immediately, state IDLE, `MARout`=0x000.
- Single write then read: write 0xDEADBEEF to 0x005, then read 0x005 (RD_WAIT=1).
  - Write: `write`=1 for exactly 1 cycle with `MARout`=0x005 and `mem_d`=0xDEADBEEF.
  - Read: `rdata`=0xDEADBEEF with `rdata_valid`+`done` 2 cycles after `req`.
- Wrap-around burst: write 4 words 0x11..0x44 from 0x1FE with `burst_len`=3, then read them back.
  - Write: `MARout` sequence is 0x1FE, 0x1FF, 0x000, 0x001; `wdata_ack` is high 4 cycles.
  - Read-back: 4 consecutive `rdata_valid` pulses with 0x11, 0x22, 0x33, 0x44.
- Wait states: RD_WAIT=3, 2-beat read -> `read` high 6 cycles; `rdata_valid` pulses in cycles 4 and 7 after `req`; `done` in cycle 7.
- Busy lockout: pulse `req` with a different `addr` during a 16-beat write -> ignored. MAR follows the original burst, exactly 16 `write` cycles occur, one `done` is issued.
- Reset mid-burst: assert `reset` during beat 2 of a 4-beat write to 0x010 -> only 0x010 and 0x011 are modified. A subsequent read of 0x012 returns its prior contents, and no `done` is seen.

Source files
------------

// File: rtl/mem_ctrl.sv
// mem_ctrl: MAR/MDR sequencer driving the RAM strobes for single and burst read/write transactions.
module mem_ctrl #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32,
  parameter int RD_WAIT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [3:0]        burst_len,
  input  logic [DATA_W-1:0] wdata,
  output logic              wdata_ack,
  output logic [DATA_W-1:0] rdata,
  output logic              rdata_valid,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] MARout,
  output logic [DATA_W-1:0] mem_d,
  input  logic [DATA_W-1:0] mem_q,
  output logic              read,
  output logic              write
);
  typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;
  state_t state, state_n;
  logic [3:0] beats, cnt;
  logic start, beat_end;
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_n;
  always_comb begin
    start = state == IDLE && req;
    beat_end = state == RD && cnt == 4'(RD_WAIT - 1);
    read = state == RD;
    write = state == WR;
    done = state == DONE;
    busy = state != IDLE;
    wdata_ack = !reset && ((start && we) || (state == WR && beats != 4'd0));
    state_n = state == IDLE ? (req ? (we ? WR : RD) : IDLE) :
              state == RD   ? (beat_end && beats == 4'd0 ? DONE : RD) :
              state == WR   ? (beats == 4'd0 ? DONE : WR) : IDLE;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      MARout <= '0;
      mem_d <= '0;
      rdata <= '0;
      rdata_valid <= 1'b0;
      beats <= 4'd0;
      cnt <= 4'd0;
    end else begin
      rdata_valid <= beat_end;
      if (start) begin
        MARout <= addr;
        beats <= burst_len;
        cnt <= 4'd0;
      end
      if (wdata_ack) mem_d <= wdata;
      if (state == RD) cnt <= beat_end ? 4'd0 : cnt + 4'd1;
      if (beat_end) rdata <= mem_q;
      if ((beat_end || state == WR) && beats != 4'd0) begin
        MARout <= MARout + ADDR_W'(1);
        beats <= beats - 4'd1;
      end
    end
endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: table-driven transactions with a read/write scoreboard, plus reset, lockout and wait-state sequences.
module tb_mem_ctrl;
  typedef struct {
    logic        we;
    logic [8:0]  addr;
    logic [3:0]  blen;
    logic [31:0] d0;
    logic [31:0] step;
    int          lat;
  } vec_t;
  logic clk = 0, reset = 1, req = 0, req3 = 0, we = 0;
  logic [8:0] addr = 0;
  logic [3:0] blen = 0;
  logic [31:0] wdata = 0;
  logic ack1, rv1, busy1, done1, rd1, wr1, ack3, rv3, busy3, done3, rd3, wr3;
  logic [31:0] rdata1, memd1, memq1, rdata3, memd3, memq3;
  logic [8:0] mar1, mar3;
  logic [31:0] ram1 [512];
  logic [31:0] ram3 [512];
  logic [31:0] ref_mem [512];
  logic poke1 = 0, poke3 = 0;
  logic [8:0] pa = 0;
  logic [31:0] pd = 0;
  int errors = 0, checks = 0, done_cnt = 0;
  logic [31:0] rq [$];
  logic [31:0] rq3 [$];
  logic [40:0] wq [$];
  vec_t tbl [7];
  always #5 clk = ~clk;
  mem_ctrl #(.RD_WAIT(1)) u1 (
    .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr), .burst_len(blen),
    .wdata(wdata), .wdata_ack(ack1), .rdata(rdata1), .rdata_valid(rv1), .busy(busy1),
    .done(done1), .MARout(mar1), .mem_d(memd1), .mem_q(memq1), .read(rd1), .write(wr1)
  );
  mem_ctrl #(.RD_WAIT(3)) u3 (
    .clk(clk), .reset(reset), .req(req3), .we(we), .addr(addr), .burst_len(blen),
    .wdata(wdata), .wdata_ack(ack3), .rdata(rdata3), .rdata_valid(rv3), .busy(busy3),
    .done(done3), .MARout(mar3), .mem_d(memd3), .mem_q(memq3), .read(rd3), .write(wr3)
  );
  always @(posedge clk) begin
    if (wr1) ram1[mar1] <= memd1;
    if (poke1) ram1[pa] <= pd;
    if (wr3) ram3[mar3] <= memd3;
    if (poke3) ram3[pa] <= pd;
  end
  assign memq1 = ram1[mar1];
  assign memq3 = ram3[mar3];
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  always @(negedge clk)
    if (!reset) begin
      if (rv1) begin
        if (rq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rdata_extra: got %0h expected no valid pulse", rdata1);
        end else chk("rdata", rdata1, rq.pop_front());
      end
      if (wr1) begin
        if (wq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL write_extra: got addr %0h data %0h expected no write", mar1, memd1);
        end else chk("write_addr_data", {mar1, memd1}, wq.pop_front());
      end
      if (rd1 && wr1) chk("read_write_exclusive", 1, 0);
      if (done1) done_cnt++;
    end
  task automatic poke(input bit to3, input logic [8:0] a, input logic [31:0] d);
    @(negedge clk);
    pa = a;
    pd = d;
    poke1 = !to3;
    poke3 = to3;
    @(negedge clk);
    poke1 = 0;
    poke3 = 0;
  endtask
  task automatic run(input vec_t v);
    int k = 0;
    bit fin = 0;
    logic [8:0] a;
    @(negedge clk);
    req = 1;
    we = v.we;
    addr = v.addr;
    blen = v.blen;
    wdata = v.d0;
    for (int b = 0; b <= int'(v.blen); b++) begin
      a = v.addr + 9'(b);
      if (v.we) begin
        ref_mem[a] = v.d0 + v.step * 32'(b);
        wq.push_back({a, ref_mem[a]});
      end else rq.push_back(ref_mem[a]);
    end
    #1 if (ack1) k = 1;
    for (int cyc = 1; cyc <= 40 && !fin; cyc++) begin
      @(negedge clk);
      if (cyc == 1) req = 0;
      wdata = v.d0 + v.step * 32'(k);
      #1;
      if (ack1) k++;
      if (done1) begin
        fin = 1;
        chk("done_latency", 64'(cyc), 64'(v.lat));
      end
    end
    if (!fin) chk("done_timeout", 0, 1);
    chk("ack_count", 64'(k), v.we ? 64'(int'(v.blen) + 1) : 64'd0);
    chk("queues_drained", 64'(rq.size() + wq.size()), 0);
  endtask
  initial begin
    int d0, nread, nv, dcyc;
    vec_t lv;
    tbl[0] = '{1'b1, 9'h005, 4'd0, 32'hDEADBEEF, 32'd0, 2};
    tbl[1] = '{1'b0, 9'h005, 4'd0, 32'd0, 32'd0, 2};
    tbl[2] = '{1'b1, 9'h1FE, 4'd3, 32'h11, 32'h11, 5};
    tbl[3] = '{1'b0, 9'h1FE, 4'd3, 32'd0, 32'd0, 5};
    tbl[4] = '{1'b1, 9'h0F0, 4'd2, 32'hCAFE0000, 32'd1, 4};
    tbl[5] = '{1'b0, 9'h0F0, 4'd2, 32'd0, 32'd0, 4};
    tbl[6] = '{1'b0, 9'h1FF, 4'd1, 32'd0, 32'd0, 3};
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs_u1", {rd1, wr1, busy1, done1, ack1, rv1, mar1, memd1, rdata1}, 0);
    chk("reset_outputs_u3", {rd3, wr3, busy3, done3, ack3, rv3, mar3, memd3, rdata3}, 0);
    @(negedge clk);
    reset = 0;
    for (int i = 0; i < 7; i++) run(tbl[i]);
    d0 = done_cnt;
    lv = '{1'b1, 9'h080, 4'd15, 32'h1000, 32'd1, 17};
    fork
      run(lv);
      begin
        repeat (6) @(negedge clk);
        req = 1;
        we = 0;
        addr = 9'h033;
        @(negedge clk);
        req = 0;
        we = 1;
        addr = 9'h080;
      end
    join
    repeat (4) @(negedge clk);
    chk("lockout_done_count", 64'(done_cnt - d0), 1);
    chk("lockout_idle_busy", busy1, 0);
    poke(0, 9'h012, 32'h12121212);
    poke(0, 9'h013, 32'h13131313);
    ref_mem[9'h012] = 32'h12121212;
    ref_mem[9'h013] = 32'h13131313;
    ref_mem[9'h010] = 32'hA0;
    ref_mem[9'h011] = 32'hA1;
    wq.push_back({9'h010, 32'hA0});
    wq.push_back({9'h011, 32'hA1});
    d0 = done_cnt;
    @(negedge clk);
    req = 1;
    we = 1;
    addr = 9'h010;
    blen = 3;
    wdata = 32'hA0;
    @(negedge clk);
    req = 0;
    wdata = 32'hA1;
    @(negedge clk);
    wdata = 32'hA2;
    @(posedge clk);
    #2 reset = 1;
    #1 chk("reset_async_outputs", {rd1, wr1, busy1, done1, ack1, rv1, mar1, memd1, rdata1}, 0);
    repeat (2) @(negedge clk);
    reset = 0;
    repeat (3) @(negedge clk);
    chk("ram_0x010_kept", ram1[9'h010], 32'hA0);
    chk("ram_0x011_kept", ram1[9'h011], 32'hA1);
    chk("ram_0x012_untouched", ram1[9'h012], 32'h12121212);
    chk("no_done_after_reset", 64'(done_cnt - d0), 0);
    chk("reset_writes_drained", 64'(wq.size()), 0);
    run('{1'b0, 9'h012, 4'd0, 32'd0, 32'd0, 2});
    run('{1'b0, 9'h010, 4'd3, 32'd0, 32'd0, 5});
    poke(1, 9'h040, 32'h0BADF00D);
    poke(1, 9'h041, 32'h600DCAFE);
    rq3.push_back(32'h0BADF00D);
    rq3.push_back(32'h600DCAFE);
    nread = 0;
    nv = 0;
    dcyc = -1;
    @(negedge clk);
    req3 = 1;
    we = 0;
    addr = 9'h040;
    blen = 1;
    for (int cyc = 1; cyc <= 12; cyc++) begin
      @(negedge clk);
      if (cyc == 1) req3 = 0;
      if (rd3) nread++;
      if (rv3) begin
        chk("wait_valid_cycle", 64'(cyc), 64'(4 + 3 * nv));
        if (rq3.size() > 0) chk("wait_rdata", rdata3, rq3.pop_front());
        nv++;
      end
      if (done3 && dcyc < 0) dcyc = cyc;
    end
    chk("wait_read_cycles", 64'(nread), 6);
    chk("wait_valid_count", 64'(nv), 2);
    chk("wait_done_cycle", 64'(dcyc), 7);
    chk("wait_rdata_hold", rdata3, 32'h600DCAFE);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
